// File: rtl/stripes_pkg.sv
// Shared definitions for the Stripes bit-serial interface: serializer FSM states,
// default geometry and the plane-counter width helper.
package stripes_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_VEC_LENGTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } ser_state_e;

  // Width of a counter that walks the bit-planes of a DATA_WIDTH-bit word.
  function automatic int plane_cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/bitplane_select.sv
// Combinational bit-plane extractor: bit k of each of VEC_LENGTH packed weights.
// Shared by the weight-side and activation-side serializers.
module bitplane_select
  import stripes_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  VEC_LENGTH = DEFAULT_VEC_LENGTH,
  localparam int KW         = plane_cnt_width(DATA_WIDTH)
) (
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] vec,
  input  logic [KW-1:0]                    k,
  output logic [VEC_LENGTH-1:0]            plane
);

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane;
    assign lane     = vec[j*DATA_WIDTH +: DATA_WIDTH];
    assign plane[j] = lane[k];
  end

endmodule

// File: rtl/stripes_weight_serializer.sv
// Stripes weight serializer: emits one signed bit-plane per cycle, MSB first, with
// MAC sideband. Define STRIPES_SER_DBUF_EN for the ping-pong (shadow) buffer build.
module stripes_weight_serializer
  import stripes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int VEC_LENGTH = DEFAULT_VEC_LENGTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_in_valid,
  output logic                             w_in_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in,
  output logic                             mac_en,
  output logic [VEC_LENGTH-1:0]            w_bit,
  output logic                             is_msb,
  output logic                             delayed_is_msb,
  output logic                             vec_start,
  output logic                             result_valid,
  output logic                             busy
);

  localparam int            KW    = plane_cnt_width(DATA_WIDTH);
  localparam int            VW    = VEC_LENGTH * DATA_WIDTH;
  localparam logic [KW-1:0] K_MSB = KW'(DATA_WIDTH - 1);

  ser_state_e            state, state_next;
  logic [KW-1:0]         k, k_next;
  logic [VW-1:0]         active, active_next, pending_vec;
  logic                  accept, pending, last_plane, load;
  logic [VEC_LENGTH-1:0] plane_next;
  logic                  rv_pipe;

  assign accept     = w_in_valid && w_in_ready;
  assign last_plane = (state == ST_SHIFT) && (k == '0);
  // A pending vector enters the active buffer on IDLE/FLUSH exit or at the k == 0 plane.
  assign load       = pending && ((state != ST_SHIFT) || last_plane);

  // NOTE: buffer contents are data, not control; they are never reset. Validity is
  // carried by the FSM state and the shadow_full flag, which are reset.
  always_ff @(posedge clk) begin
    active <= active_next;
  end

`ifdef STRIPES_SER_DBUF_EN
  logic [VW-1:0] shadow;
  logic          shadow_full;

  assign w_in_ready  = !shadow_full;
  assign pending     = shadow_full || accept;
  // An empty shadow means a vector accepted on a load cycle bypasses straight to active.
  assign pending_vec = shadow_full ? shadow : w_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_full <= 1'b0;
    end else if (load) begin
      shadow_full <= 1'b0;
    end else if (accept) begin
      shadow_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !load) begin
      shadow <= w_in;
    end
  end
`else
  assign w_in_ready  = (state == ST_IDLE);
  assign pending     = accept;
  assign pending_vec = w_in;
`endif

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    k_next      = k;
    active_next = active;
    if (load) begin
      state_next  = ST_SHIFT;
      k_next      = K_MSB;
      active_next = pending_vec;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_SHIFT: begin
          if (k != '0) begin
            k_next = k - KW'(1);
          end else begin
            state_next = ST_FLUSH;
            k_next     = K_MSB;
          end
        end
        ST_FLUSH: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          k_next     = K_MSB;
        end
      endcase
    end
  end

  bitplane_select #(
    .DATA_WIDTH(DATA_WIDTH),
    .VEC_LENGTH(VEC_LENGTH)
  ) u_plane_sel (
    .vec   (active_next),
    .k     (k_next),
    .plane (plane_next)
  );

  // Outputs are registered from the next-state values so they line up with the
  // state they describe; the flush plane is forced to zero.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      k              <= K_MSB;
      mac_en         <= 1'b0;
      busy           <= 1'b0;
      is_msb         <= 1'b0;
      vec_start      <= 1'b0;
      w_bit          <= '0;
      delayed_is_msb <= 1'b0;
      rv_pipe        <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      mac_en    <= (state_next != ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      is_msb    <= (state_next == ST_SHIFT) && (k_next == K_MSB);
      vec_start <= (state_next == ST_SHIFT) && (k_next == K_MSB);
      w_bit     <= (state_next == ST_SHIFT) ? plane_next : '0;
      if (mac_en) begin
        delayed_is_msb <= is_msb;
      end
      // The accumulator is complete two cycles after the k == 0 plane.
      rv_pipe      <= last_plane;
      result_valid <= rv_pipe;
    end
  end

endmodule

// File: tb/tb_stripes_weight_serializer.sv
// Self-checking bench for stripes_weight_serializer: a schedule-level model of when
// each vector's planes, flush and result appear, plus a bit-serial MAC on the outputs.
module tb_stripes_weight_serializer;

  localparam int DW = 8;
  localparam int VL = 16;
  localparam int VW = DW * VL;
`ifdef STRIPES_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  // Minimum spacing between consecutive vectors' first planes.
  localparam int GAP = DBUF ? DW : DW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          w_in_valid = 1'b0;
  logic [VW-1:0] w_in = '0;
  logic          w_in_ready, mac_en, is_msb, delayed_is_msb, vec_start, result_valid, busy;
  logic [VL-1:0] w_bit;

  stripes_weight_serializer #(
    .DATA_WIDTH(DW),
    .VEC_LENGTH(VL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .w_in_valid     (w_in_valid),
    .w_in_ready     (w_in_ready),
    .w_in           (w_in),
    .mac_en         (mac_en),
    .w_bit          (w_bit),
    .is_msb         (is_msb),
    .delayed_is_msb (delayed_is_msb),
    .vec_start      (vec_start),
    .result_valid   (result_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Model: each accepted vector with its accept cycle a and first-plane cycle s.
  typedef struct {
    int            a;
    int            s;
    int            act;
    logic [VW-1:0] v;
  } sched_t;

  sched_t sched[$];
  int     act_val = 1;
  bit     armed = 1'b0;
  bit     m_acc = 1'b0;

  // Observations of the DUT, cleared per test.
  int     msb_cyc[$];
  int     rv_cyc[$];
  int     dmsb_cyc[$];
  longint mac_res[$];
  bit     lane0_bits[$];
  int     busy_cnt = 0;

  function automatic longint dot_of(input logic [VW-1:0] v, input int a);
    longint s;
    s = 0;
    for (int j = 0; j < VL; j++) s += longint'($signed(v[j*DW +: DW])) * a;
    return s;
  endfunction

  // Bit-serial MAC driven by the DUT outputs; acc_h2 is the accumulator two cycles ago.
  longint acc = 0;
  longint acc_h1 = 0;
  longint acc_h2 = 0;

  always @(negedge clk) begin
    logic          exp_en, exp_msb, exp_dmsb, exp_rv, flush_c, shadow_occ, exp_ready;
    logic [VL-1:0] exp_wb;
    longint        exp_dot, dot_now;
    int            kk, s_new;
    m_acc      = 1'b0;
    exp_en     = 1'b0;
    exp_msb    = 1'b0;
    exp_dmsb   = 1'b0;
    exp_rv     = 1'b0;
    flush_c    = 1'b0;
    shadow_occ = 1'b0;
    exp_ready  = 1'b0;
    exp_wb     = '0;
    exp_dot    = 0;
    if (armed) begin
      for (int i = 0; i < sched.size(); i++) begin
        if (cyc >= sched[i].s && cyc <= sched[i].s + DW - 1) begin
          exp_en = 1'b1;
          kk = DW - 1 - (cyc - sched[i].s);
          for (int j = 0; j < VL; j++) exp_wb[j] = sched[i].v[j*DW + kk];
          if (cyc == sched[i].s) exp_msb = 1'b1;
        end
        if (cyc == sched[i].s + DW) flush_c = 1'b1;
        if (cyc == sched[i].s + DW + 1) begin
          exp_rv  = 1'b1;
          exp_dot = dot_of(sched[i].v, sched[i].act);
        end
        if (cyc == sched[i].s + 1) exp_dmsb = 1'b1;
        if (sched[i].a < cyc && cyc < sched[i].s) shadow_occ = 1'b1;
      end
      exp_en    = exp_en | flush_c;
      exp_ready = DBUF ? !shadow_occ : !exp_en;

      check("mac_en", mac_en, exp_en);
      check("w_bit", w_bit, exp_wb);
      check("is_msb", is_msb, exp_msb);
      check("vec_start", vec_start, exp_msb);
      check("delayed_is_msb", delayed_is_msb, exp_dmsb);
      check("result_valid", result_valid, exp_rv);
      check("busy", busy, exp_en);
      check("w_in_ready", w_in_ready, exp_ready);
      if (exp_rv && result_valid) check("mac_result", acc_h2, exp_dot);

      if (is_msb) msb_cyc.push_back(cyc);
      if (delayed_is_msb) dmsb_cyc.push_back(cyc);
      if (result_valid) begin
        rv_cyc.push_back(cyc);
        mac_res.push_back(acc_h2);
      end
      if (busy) busy_cnt++;
      if (mac_en) lane0_bits.push_back(w_bit[0]);

      dot_now = 0;
      for (int j = 0; j < VL; j++) if (w_bit[j]) dot_now += act_val;
      if (mac_en) acc = is_msb ? -dot_now : acc * 2 + dot_now;
      acc_h2 = acc_h1;
      acc_h1 = acc;
    end
    if (reset) begin
      sched.delete();
      armed = 1'b1;
    end else if (armed && w_in_valid && exp_ready) begin
      s_new = cyc + 1;
      if (sched.size() > 0 && sched[$].s + GAP > s_new) s_new = sched[$].s + GAP;
      sched.push_back('{a: cyc, s: s_new, act: act_val, v: w_in});
      m_acc = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_obs();
    msb_cyc.delete();
    rv_cyc.delete();
    dmsb_cyc.delete();
    mac_res.delete();
    lane0_bits.delete();
    busy_cnt = 0;
  endtask

  // Offers v until the model accepts it; returns the accept cycle, one cycle later.
  task automatic send(input logic [VW-1:0] v, output int acc_cyc);
    int waited;
    waited = 0;
    acc_cyc = -1;
    w_in = v;
    w_in_valid = 1'b1;
    while (acc_cyc < 0) begin
      @(negedge clk);
      #1;
      if (m_acc) begin
        acc_cyc = cyc;
      end else if (++waited > 64) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout at cycle %0d: got no accept, expected one within 64 cycles", cyc);
        acc_cyc = cyc;
      end
      tick();
    end
    w_in_valid = 1'b0;
  endtask

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] b);
    return {VL{b}};
  endfunction

  function automatic int first_of(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  logic [VW-1:0] va, vb, vc, v1, vfs;
  int c, c0, c1, c2, bits;

  initial begin
    for (int j = 0; j < VL; j++) va[j*DW +: DW] = 8'(j * 37 + 5);
    vb  = fill(8'h01);
    vc  = fill(8'h7f);
    v1  = '0;
    v1[DW-1:0] = 8'h85;
    vfs = fill(8'h80);

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Single vector, lane 0 = -123.
    clear_obs();
    act_val = 1;
    send(v1, c);
    idle(14);
    check("model_dot_85", dot_of(v1, 1), -123);
    check("t1_msb_count", msb_cyc.size(), 1);
    check("t1_msb_cycle", first_of(msb_cyc, 0), c + 1);
    check("t1_dmsb_cycle", first_of(dmsb_cyc, 0), c + 2);
    check("t1_rv_cycle", first_of(rv_cyc, 0), c + 10);
    check("t1_mac_result", (mac_res.size() > 0) ? mac_res[0] : 0, -123);
    bits = 0;
    for (int i = 0; i < 8 && i < lane0_bits.size(); i++) bits = (bits << 1) | int'(lane0_bits[i]);
    check("t1_lane0_planes", bits, 'h85);
    check("t1_busy_cycles", busy_cnt, 9);

    // Three vectors offered back to back.
    clear_obs();
    act_val = 3;
    send(va, c0);
    send(vb, c1);
    send(vc, c2);
    idle(35);
    check("t2_msb_1", first_of(msb_cyc, 1), c0 + 1 + GAP);
    check("t2_msb_2", first_of(msb_cyc, 2), c0 + 1 + 2 * GAP);
    check("t2_rv_0", first_of(rv_cyc, 0), c0 + 10);
    check("t2_rv_1", first_of(rv_cyc, 1), c0 + 10 + GAP);
    check("t2_rv_2", first_of(rv_cyc, 2), c0 + 10 + 2 * GAP);
    check("t2_mac_b", (mac_res.size() > 1) ? mac_res[1] : 0, 48);
    check("t2_mac_c", (mac_res.size() > 2) ? mac_res[2] : 0, 6096);
    check("t2_busy_cycles", busy_cnt, DBUF ? 25 : 27);

    // Reset asserted while plane k = 4 is on the outputs.
    clear_obs();
    act_val = 1;
    send(va, c);
    idle(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("t3_mac_en", mac_en, 0);
    check("t3_is_msb", is_msb, 0);
    check("t3_busy", busy, 0);
    check("t3_ready", w_in_ready, 1);
    tick();
    idle(14);
    check("t3_no_result", rv_cyc.size(), 0);

    // Full scale: all lanes -128, act 127.
    clear_obs();
    act_val = 127;
    send(vfs, c);
    idle(14);
    check("model_dot_full", dot_of(vfs, 127), -260096);
    check("t4_mac_result", (mac_res.size() > 0) ? mac_res[0] : 0, -260096);

    // Second vector offered in the FLUSH cycle of the first.
    clear_obs();
    act_val = 2;
    send(va, c);
    idle(8);
    send(vb, c1);
    idle(14);
    check("t5_accept_cycle", c1, DBUF ? c + 9 : c + 10);
    check("t5_msb_1", first_of(msb_cyc, 1), c1 + 1);
    check("t5_rv_1", first_of(rv_cyc, 1), c1 + DW + 2);
    check("t5_mac_b", (mac_res.size() > 1) ? mac_res[1] : 0, 32);

    // Second vector offered in the k == 0 plane of the first.
    clear_obs();
    act_val = 1;
    send(vc, c);
    idle(7);
    send(va, c1);
    idle(14);
    check("t6_msb_spacing", first_of(msb_cyc, 1) - first_of(msb_cyc, 0), GAP);
    check("t6_busy_cycles", busy_cnt, DBUF ? 17 : 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
